// File: rtl/frame_loader.sv
// frame_loader: assembles a byte stream into 12-bit RGB pixels and writes
// them sequentially into a frame buffer starting at address 0.
// Two bytes per pixel: {R,G} then {xxxx,B}.
// Optional build macro FRAME_LOADER_CSUM_EN: after the last pixel, one more
// byte is accepted and compared against the modulo-256 sum of all pixel
// bytes; the result is reported on csum_err.
module frame_loader #(
  parameter int FRAME_PIXELS = 76800,
  parameter int ADDR_W       = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [11:0]       wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              csum_err
);

`ifdef FRAME_LOADER_CSUM_EN
  typedef enum logic [1:0] {IDLE, RECV_HI, RECV_LO, RECV_CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV_HI, RECV_LO} state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pix_cnt;
  logic [7:0]        rg_byte;
  logic              accept;
  logic              hi_acc;
  logic              pix_wr;
  logic              frame_end;

  // Next-state and per-cycle control strobes; start overrides any byte.
  always_comb begin
    state_next = state;
    accept     = in_valid & in_ready;
    hi_acc     = 1'b0;
    pix_wr     = 1'b0;
    frame_end  = 1'b0;
    if (start) begin
      state_next = RECV_HI;
    end else begin
      case (state)
        RECV_HI: begin
          if (accept) begin
            hi_acc     = 1'b1;
            state_next = RECV_LO;
          end
        end
        RECV_LO: begin
          if (accept) begin
            pix_wr = 1'b1;
            if (pix_cnt == LAST_PIX) begin
`ifdef FRAME_LOADER_CSUM_EN
              state_next = RECV_CSUM;
`else
              state_next = IDLE;
              frame_end  = 1'b1;
`endif
            end else begin
              state_next = RECV_HI;
            end
          end
        end
`ifdef FRAME_LOADER_CSUM_EN
        RECV_CSUM: begin
          if (accept) begin
            frame_end  = 1'b1;
            state_next = IDLE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // State register; in_ready is registered from the next state so it is
  // high exactly while a receive state is current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != IDLE);
    end
  end

  // Pixel assembly, write port and frame status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt    <= '0;
      rg_byte    <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      we         <= pix_wr;
      frame_done <= frame_end;
      if (start) begin
        pix_cnt <= '0;
        busy    <= 1'b1;
      end else if (frame_end) begin
        busy <= 1'b0;
      end
      if (hi_acc) rg_byte <= in_data;
      if (pix_wr) begin
        waddr   <= pix_cnt;
        wdata   <= {rg_byte, in_data[3:0]};
        pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + ADDR_W'(1);
      end
    end
  end

`ifdef FRAME_LOADER_CSUM_EN
  logic [7:0] csum;

  // Running byte sum over the pixel bytes and the end-of-frame compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum     <= '0;
      csum_err <= 1'b0;
    end else if (start) begin
      csum     <= '0;
      csum_err <= 1'b0;
    end else begin
      if (hi_acc || pix_wr) csum <= csum + in_data;
      if (frame_end) csum_err <= (in_data != csum);
    end
  end
`else
  assign csum_err = 1'b0;
`endif

endmodule
